memory_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the core's instruction-fetch path and
//  its load/store path, so the core runs from a unified program/data memory.

---
 rtl/core_arbiter_pkg.sv | 22 ++
 rtl/arb_latency_timer.sv | 36 +++
 rtl/memory_port_arbiter.sv | 136 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package core_arbiter_pkg;

  // Arbiter FSM: grants happen only in IDLE, one access in flight otherwise.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  // Which requester owns the memory port for the current grant.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  // Bits needed to hold the values 0..max_value (never less than 1).
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/arb_latency_timer.sv
// Load/decrement counter that marks the cycle in which memory read data is valid.
module arb_latency_timer
  import core_arbiter_pkg::*;
#(
  parameter int mem_latency = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = cnt_width(mem_latency);
  localparam logic [W-1:0] LOAD_VALUE = W'(mem_latency);
  localparam logic [W-1:0] LAST_VALUE = W'(1);

  logic [W-1:0] count;

  // Count register: loaded on a grant, then counts down to 0 and stays there.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Final busy cycle: the count reaches 0 at the end of this cycle, which is
  // exactly mem_latency cycles after the grant.
  assign done = (count == LAST_VALUE);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data has priority unless fetch has waited starve_limit cycles.
module memory_port_arbiter
  import core_arbiter_pkg::*;
#(
  parameter int data_bits           = 32,
  parameter int memory_address_bits = 10,
  parameter int mem_latency         = 1,
  parameter int starve_limit        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           if_req,
  input  logic [memory_address_bits-1:0] if_addr,
  output logic                           if_gnt,
  output logic                           if_valid,
  output logic [data_bits-1:0]           if_rdata,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [memory_address_bits-1:0] d_addr,
  input  logic [data_bits-1:0]           d_wdata,
  output logic                           d_gnt,
  output logic                           d_valid,
  output logic [data_bits-1:0]           d_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [memory_address_bits-1:0] mem_addr,
  output logic [data_bits-1:0]           mem_wdata,
  input  logic [data_bits-1:0]           mem_rdata,
  output logic                           busy
);

  localparam int SW = cnt_width(starve_limit);
  localparam logic [SW-1:0] STARVE_MAX = SW'(starve_limit);

  arb_state_t          state;
  arb_state_t          state_next;
  req_id_t             winner;
  logic                grant_ok;
  logic                timer_done;
  logic                d_load_q;
  logic [SW-1:0]       starve_cnt;
  logic [data_bits-1:0] if_rdata_q;
  logic [data_bits-1:0] d_rdata_q;

  arb_latency_timer #(
    .mem_latency(mem_latency)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (mem_en),
    .done (timer_done)
  );

  // Grant mux, completion pulses and next-state logic.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_valid   = 1'b0;
    d_valid    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    winner     = (if_req && (!d_req || starve_cnt == STARVE_MAX)) ? REQ_IF : REQ_D;
    grant_ok   = (state == IDLE) && !reset && (if_req || d_req);

    case (state)
      IDLE: begin
        if (grant_ok) begin
          mem_en = 1'b1;
          if (winner == REQ_IF) begin
            if_gnt     = 1'b1;
            mem_addr   = if_addr;
            state_next = BUSY_IF;
          end else begin
            d_gnt      = 1'b1;
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            state_next = BUSY_D;
          end
        end
      end
      BUSY_IF: begin
        if (timer_done) begin
          if_valid   = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (timer_done) begin
          d_valid    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, fetch starvation counter, load flag and read-data holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      d_load_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (d_gnt) begin
        d_load_q <= !d_we;
      end
      if (if_valid) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_valid && d_load_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Read data is presented straight from memory in the valid cycle and held afterwards.
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = (d_valid && d_load_q) ? mem_rdata : d_rdata_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: instance a (latency 1) and instance b
// (latency 3), each with a behavioural memory whose unwritten words read A500_0000|addr.
module tb_memory_port_arbiter;

  localparam int DB = 32;
  localparam int AB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance a: mem_latency = 1, starve_limit = 4.
  logic          a_reset, a_if_req, a_d_req, a_d_we;
  logic [AB-1:0] a_if_addr, a_d_addr, a_mem_addr;
  logic [DB-1:0] a_d_wdata, a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_if_gnt, a_if_valid, a_d_gnt, a_d_valid, a_mem_en, a_mem_we, a_busy;
  logic [DB-1:0] a_rd = '0;

  // Instance b: mem_latency = 3, starve_limit = 4.
  logic          b_reset, b_if_req, b_d_req, b_d_we;
  logic [AB-1:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [DB-1:0] b_d_wdata, b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we, b_busy;
  logic [DB-1:0] b_p0 = '0, b_p1 = '0, b_p2 = '0;

  memory_port_arbiter #(
    .data_bits(DB), .memory_address_bits(AB), .mem_latency(1), .starve_limit(4)
  ) a_dut (
    .clk(clk), .reset(a_reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_valid(a_if_valid),
    .if_rdata(a_if_rdata), .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_valid(a_d_valid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  memory_port_arbiter #(
    .data_bits(DB), .memory_address_bits(AB), .mem_latency(3), .starve_limit(4)
  ) b_dut (
    .clk(clk), .reset(b_reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid),
    .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [DB-1:0] pat(input logic [AB-1:0] addr);
    return 32'hA500_0000 | {{(DB-AB){1'b0}}, addr};
  endfunction

  // Behavioural memories: written words tracked, unwritten words read the pattern.
  logic [DB-1:0] mem_a [0:1023];
  bit            wr_a  [0:1023];
  logic [DB-1:0] mem_b [0:1023];
  bit            wr_b  [0:1023];

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
      wr_a[a_mem_addr]  <= 1'b1;
    end
    a_rd <= a_mem_en ? (wr_a[a_mem_addr] ? mem_a[a_mem_addr] : pat(a_mem_addr)) : '0;
  end
  assign a_mem_rdata = a_rd;

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) begin
      mem_b[b_mem_addr] <= b_mem_wdata;
      wr_b[b_mem_addr]  <= 1'b1;
    end
    b_p0 <= b_mem_en ? (wr_b[b_mem_addr] ? mem_b[b_mem_addr] : pat(b_mem_addr)) : '0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  // Protocol invariants sampled every cycle out of reset on both instances.
  always @(negedge clk) begin
    if (!a_reset) begin
      vectors++;
      if ((a_if_gnt && a_d_gnt) || (a_mem_en != (a_if_gnt || a_d_gnt)) ||
          (a_busy && (a_if_gnt || a_d_gnt)) ||
          (!a_mem_en && (a_mem_we || a_mem_addr != '0 || a_mem_wdata != '0))) begin
        miscompares++;
        $display("FAIL a_invariant @%0t: if_gnt=%b d_gnt=%b mem_en=%b busy=%b we=%b addr=%h, required one gnt iff mem_en, none when busy, idle bus 0",
                 $time, a_if_gnt, a_d_gnt, a_mem_en, a_busy, a_mem_we, a_mem_addr);
      end
    end
    if (!b_reset) begin
      vectors++;
      if ((b_if_gnt && b_d_gnt) || (b_mem_en != (b_if_gnt || b_d_gnt)) ||
          (b_busy && (b_if_gnt || b_d_gnt)) ||
          (!b_mem_en && (b_mem_we || b_mem_addr != '0 || b_mem_wdata != '0))) begin
        miscompares++;
        $display("FAIL b_invariant @%0t: if_gnt=%b d_gnt=%b mem_en=%b busy=%b we=%b addr=%h, required one gnt iff mem_en, none when busy, idle bus 0",
                 $time, b_if_gnt, b_d_gnt, b_mem_en, b_busy, b_mem_we, b_mem_addr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_if_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b1;
    a_if_addr = 10'h3FF; a_d_addr = 10'h155; a_d_wdata = 32'hFFFF_FFFF;
    b_if_req = 1'b1; b_d_req = 1'b1; b_d_we = 1'b0;
    b_if_addr = 10'h2AA; b_d_addr = 10'h0F0; b_d_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({a_if_gnt, a_if_valid, a_if_rdata, a_d_gnt, a_d_valid, a_d_rdata, a_mem_en,
         a_mem_we, a_mem_addr, a_mem_wdata, a_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_a: gnt=%b/%b en=%b we=%b addr=%h busy=%b, required all 0",
               a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_busy);
    end
    vectors++;
    if ({b_if_gnt, b_if_valid, b_if_rdata, b_d_gnt, b_d_valid, b_d_rdata, b_mem_en,
         b_mem_we, b_mem_addr, b_mem_wdata, b_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_b: gnt=%b/%b en=%b we=%b addr=%h busy=%b, required all 0",
               b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_mem_addr, b_busy);
    end
    #1;
    a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0; a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
    b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0; b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;
    a_reset = 1'b0; b_reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    next_cycle();
    a_if_req = 1'b1; a_if_addr = 10'h004;
    @(negedge clk);
    vectors++;
    if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_mem_addr} !== {5'b10100, 10'h004}) begin
      miscompares++;
      $display("FAIL fetch_grant: if_gnt=%b d_gnt=%b en=%b we=%b busy=%b addr=%h, required 1 0 1 0 0 004",
               a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_mem_addr);
    end
    next_cycle();
    a_if_req = 1'b0; a_if_addr = '0;
    @(negedge clk);
    vectors++;
    if ({a_if_valid, a_busy, a_if_gnt, a_mem_en} !== 4'b1100 || a_if_rdata !== pat(10'h004)) begin
      miscompares++;
      $display("FAIL fetch_valid: valid=%b busy=%b gnt=%b en=%b rdata=%h, required 1 1 0 0 %h",
               a_if_valid, a_busy, a_if_gnt, a_mem_en, a_if_rdata, pat(10'h004));
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({a_if_valid, a_busy} !== 2'b00 || a_if_rdata !== pat(10'h004)) begin
      miscompares++;
      $display("FAIL fetch_hold: valid=%b busy=%b rdata=%h, required 0 0 %h",
               a_if_valid, a_busy, a_if_rdata, pat(10'h004));
    end
  endtask

  task automatic test_data_priority();
    next_cycle();
    a_if_req = 1'b1; a_if_addr = 10'h008;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 10'h010;
    @(negedge clk);
    vectors++;
    if ({a_d_gnt, a_if_gnt, a_mem_we, a_mem_addr} !== {3'b100, 10'h010}) begin
      miscompares++;
      $display("FAIL prio_d_first: d_gnt=%b if_gnt=%b we=%b addr=%h, required 1 0 0 010",
               a_d_gnt, a_if_gnt, a_mem_we, a_mem_addr);
    end
    next_cycle();
    a_d_req = 1'b0; a_d_addr = '0;
    @(negedge clk);
    vectors++;
    if ({a_d_valid, a_if_gnt} !== 2'b10 || a_d_rdata !== pat(10'h010)) begin
      miscompares++;
      $display("FAIL prio_d_valid: d_valid=%b if_gnt=%b d_rdata=%h, required 1 0 %h",
               a_d_valid, a_if_gnt, a_d_rdata, pat(10'h010));
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({a_if_gnt, a_d_gnt, a_mem_addr} !== {2'b10, 10'h008}) begin
      miscompares++;
      $display("FAIL prio_if_next: if_gnt=%b d_gnt=%b addr=%h, required 1 0 008",
               a_if_gnt, a_d_gnt, a_mem_addr);
    end
    next_cycle();
    a_if_req = 1'b0; a_if_addr = '0;
    @(negedge clk);
    vectors++;
    if ({a_if_valid, a_d_valid} !== 2'b10 || a_if_rdata !== pat(10'h008)) begin
      miscompares++;
      $display("FAIL prio_if_valid: if_valid=%b d_valid=%b if_rdata=%h, required 1 0 %h",
               a_if_valid, a_d_valid, a_if_rdata, pat(10'h008));
    end
  endtask

  task automatic test_store();
    next_cycle();
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 10'h020; a_d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({a_d_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {3'b111, 10'h020} || a_mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL store_grant: d_gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 020 deadbeef",
               a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    next_cycle();
    a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    @(negedge clk);
    vectors++;
    if ({a_d_valid, a_mem_we, a_mem_en} !== 3'b100 || a_d_rdata !== pat(10'h010)) begin
      miscompares++;
      $display("FAIL store_done: d_valid=%b we=%b en=%b d_rdata=%h, required 1 0 0 %h (unchanged)",
               a_d_valid, a_mem_we, a_mem_en, a_d_rdata, pat(10'h010));
    end
    next_cycle();
    a_d_req = 1'b1; a_d_addr = 10'h020;
    @(negedge clk);
    vectors++;
    if ({a_d_gnt, a_mem_we, a_mem_addr} !== {2'b10, 10'h020}) begin
      miscompares++;
      $display("FAIL store_reload_gnt: d_gnt=%b we=%b addr=%h, required 1 0 020",
               a_d_gnt, a_mem_we, a_mem_addr);
    end
    next_cycle();
    a_d_req = 1'b0; a_d_addr = '0;
    @(negedge clk);
    vectors++;
    if (a_d_valid !== 1'b1 || a_d_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL store_reload_data: d_valid=%b d_rdata=%h, required 1 deadbeef",
               a_d_valid, a_d_rdata);
    end
  endtask

  task automatic test_starvation();
    next_cycle();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 10'h030;
    a_if_req = 1'b1; a_if_addr = 10'h040;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (k % 2 == 0) begin
        if ({a_d_gnt, a_if_gnt} !== 2'b10) begin
          miscompares++;
          $display("FAIL starve_d_gnt_%0d: d_gnt=%b if_gnt=%b, required 1 0", k, a_d_gnt, a_if_gnt);
        end
      end else begin
        if ({a_d_valid, a_if_gnt} !== 2'b10 || a_d_rdata !== pat(10'h030)) begin
          miscompares++;
          $display("FAIL starve_d_valid_%0d: d_valid=%b if_gnt=%b d_rdata=%h, required 1 0 %h",
                   k, a_d_valid, a_if_gnt, a_d_rdata, pat(10'h030));
        end
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if ({a_if_gnt, a_d_gnt, a_mem_addr} !== {2'b10, 10'h040}) begin
      miscompares++;
      $display("FAIL starve_if_wins: if_gnt=%b d_gnt=%b addr=%h, required 1 0 040",
               a_if_gnt, a_d_gnt, a_mem_addr);
    end
    next_cycle();
    a_if_req = 1'b0; a_if_addr = '0;
    @(negedge clk);
    vectors++;
    if (a_if_valid !== 1'b1 || a_if_rdata !== pat(10'h040) || a_dut.starve_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL starve_if_valid: valid=%b rdata=%h starve_cnt=%0d, required 1 %h 0",
               a_if_valid, a_if_rdata, a_dut.starve_cnt, pat(10'h040));
    end
    next_cycle();
    a_if_req = 1'b1; a_if_addr = 10'h044;
    @(negedge clk);
    vectors++;
    if ({a_d_gnt, a_if_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL starve_cleared: d_gnt=%b if_gnt=%b, required 1 0", a_d_gnt, a_if_gnt);
    end
    next_cycle();
    a_d_req = 1'b0; a_d_addr = '0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({a_if_gnt, a_mem_addr} !== {1'b1, 10'h044}) begin
      miscompares++;
      $display("FAIL starve_if_alone: if_gnt=%b addr=%h, required 1 044", a_if_gnt, a_mem_addr);
    end
    next_cycle();
    a_if_req = 1'b0; a_if_addr = '0;
    @(negedge clk);
    vectors++;
    if (a_if_valid !== 1'b1 || a_if_rdata !== pat(10'h044)) begin
      miscompares++;
      $display("FAIL starve_if_alone_data: valid=%b rdata=%h, required 1 %h",
               a_if_valid, a_if_rdata, pat(10'h044));
    end
  endtask

  task automatic test_reset_mid_access();
    next_cycle();
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'h050;
    @(negedge clk);
    vectors++;
    if (b_d_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_gnt: d_gnt=%b, required 1", b_d_gnt);
    end
    next_cycle();
    b_d_req = 1'b0; b_d_addr = '0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({b_busy, b_d_valid} !== 2'b10 || b_dut.u_timer.count !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: busy=%b d_valid=%b count=%0d, required 1 0 2",
               b_busy, b_d_valid, b_dut.u_timer.count);
    end
    #1;
    b_reset = 1'b1;
    #1;
    vectors++;
    if ({b_busy, b_d_valid, b_mem_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_async: busy=%b d_valid=%b en=%b, required 0 0 0", b_busy, b_d_valid, b_mem_en);
    end
    @(negedge clk);
    #1;
    b_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({b_busy, b_d_valid} !== 2'b00 || b_d_rdata !== '0) begin
        miscompares++;
        $display("FAIL midrst_quiet_%0d: busy=%b d_valid=%b d_rdata=%h, required 0 0 0",
                 k, b_busy, b_d_valid, b_d_rdata);
      end
    end
    next_cycle();
    b_d_req = 1'b1; b_d_addr = 10'h060;
    @(negedge clk);
    vectors++;
    if ({b_d_gnt, b_mem_addr} !== {1'b1, 10'h060}) begin
      miscompares++;
      $display("FAIL midrst_fresh_gnt: d_gnt=%b addr=%h, required 1 060", b_d_gnt, b_mem_addr);
    end
    next_cycle();
    b_d_req = 1'b0; b_d_addr = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (b_busy !== 1'b1 || b_d_valid !== (k == 3)) begin
        miscompares++;
        $display("FAIL midrst_fresh_c%0d: busy=%b d_valid=%b, required 1 %b", k, b_busy, b_d_valid, (k == 3));
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if ({b_busy, b_d_valid} !== 2'b00 || b_d_rdata !== pat(10'h060)) begin
      miscompares++;
      $display("FAIL midrst_fresh_data: busy=%b d_valid=%b d_rdata=%h, required 0 0 %h",
               b_busy, b_d_valid, b_d_rdata, pat(10'h060));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_store();
    test_starvation();
    test_reset_mid_access();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
